// File: rtl/branch_resolve_unit.sv
// Branch resolution for the 5-stage MIPS core: carries the D-stage prediction
// through E/M, resolves the condition in E, trains the predictor and redirects fetch.
module branch_resolve_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallE,
  input  logic             stallM,
  input  logic             flushE,
  input  logic             flushM,
  input  logic             branchD,
  input  logic [2:0]       branch_typeD,
  input  logic             pred_takeD,
  input  logic [31:0]      pcD,
  input  logic [31:0]      branch_targetD,
  input  logic [31:0]      srcaE,
  input  logic [31:0]      srcbE,
  input  logic             redirect_ready,
  output logic             branchM,
  output logic             actual_takeM,
  output logic [31:0]      pcM,
  output logic             mispredictM,
  output logic             flush_frontend,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count,
  output logic             dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic        e_valid_q, e_valid_d, e_pred_q, e_pred_d;
  logic [2:0]  e_type_q, e_type_d;
  logic [31:0] e_pc_q, e_pc_d, e_tgt_q, e_tgt_d;
  logic        m_valid_q, m_valid_d, m_pred_q, m_pred_d, m_take_q, m_take_d;
  logic [31:0] m_pc_q, m_pc_d, m_tgt_q, m_tgt_d;
  state_t      state_q;
  logic [31:0] rpc_q;
  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

  logic        take_e, commit, mis_now, in_wait;
  logic [31:0] calc_pc;

  always_comb begin
    take_e = 1'b0;
    case (e_type_q)
      3'b000:  take_e = (srcaE == srcbE);
      3'b001:  take_e = (srcaE != srcbE);
      3'b010:  take_e = ($signed(srcaE) <= 0);
      3'b011:  take_e = ($signed(srcaE) > 0);
      3'b100:  take_e = ($signed(srcaE) < 0);
      3'b101:  take_e = ($signed(srcaE) >= 0);
      default: take_e = 1'b0;
    endcase
  end

  // A D-stage instruction seen while the front end is squashed is wrong-path.
  always_comb begin
    e_valid_d = e_valid_q;
    e_type_d  = e_type_q;
    e_pred_d  = e_pred_q;
    e_pc_d    = e_pc_q;
    e_tgt_d   = e_tgt_q;
    if (flushE) begin
      e_valid_d = 1'b0;
    end else if (!stallE) begin
      e_valid_d = branchD & ~flush_frontend;
      e_type_d  = branch_typeD;
      e_pred_d  = pred_takeD;
      e_pc_d    = pcD;
      e_tgt_d   = branch_targetD;
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_pred_d  = m_pred_q;
    m_take_d  = m_take_q;
    m_pc_d    = m_pc_q;
    m_tgt_d   = m_tgt_q;
    if (flushM) begin
      m_valid_d = 1'b0;
    end else if (!stallM) begin
      if (stallE) begin
        m_valid_d = 1'b0;
      end else begin
        m_valid_d = e_valid_q;
        m_pred_d  = e_pred_q;
        m_take_d  = take_e;
        m_pc_d    = e_pc_q;
        m_tgt_d   = e_tgt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid_q <= 1'b0;
      e_type_q  <= 3'b000;
      e_pred_q  <= 1'b0;
      e_pc_q    <= 32'd0;
      e_tgt_q   <= 32'd0;
      m_valid_q <= 1'b0;
      m_pred_q  <= 1'b0;
      m_take_q  <= 1'b0;
      m_pc_q    <= 32'd0;
      m_tgt_q   <= 32'd0;
    end else begin
      e_valid_q <= e_valid_d;
      e_type_q  <= e_type_d;
      e_pred_q  <= e_pred_d;
      e_pc_q    <= e_pc_d;
      e_tgt_q   <= e_tgt_d;
      m_valid_q <= m_valid_d;
      m_pred_q  <= m_pred_d;
      m_take_q  <= m_take_d;
      m_pc_q    <= m_pc_d;
      m_tgt_q   <= m_tgt_d;
    end
  end

  // Not-taken resumes past the delay slot, which stays live in E.
  assign commit  = m_valid_q & ~stallM;
  assign mis_now = commit & (m_pred_q ^ m_take_q);
  assign calc_pc = m_take_q ? m_tgt_q : (m_pc_q + 32'd8);
  assign in_wait = (state_q == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rpc_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: if (mis_now && !redirect_ready) begin
          state_q <= S_WAIT;
          rpc_q   <= calc_pc;
        end
        S_WAIT: if (redirect_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (commit && (br_cnt_q != '1))   br_cnt_q  <= br_cnt_q + CNT_ONE;
      if (mis_now && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + CNT_ONE;
    end
  end

  assign branchM        = commit;
  assign actual_takeM   = m_take_q;
  assign pcM            = m_pc_q;
  assign mispredictM    = mis_now;
  assign redirect_valid = in_wait | mis_now;
  assign flush_frontend = in_wait | mis_now;
  assign redirect_pc    = in_wait ? rpc_q : (mis_now ? calc_pc : 32'd0);
  assign br_count       = br_cnt_q;
  assign mispred_count  = mis_cnt_q;
  assign dbg_state      = in_wait;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed cases then randomized branches checked
// against a condition/redirect reference model and saturating counter model.
module tb_branch_resolve_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stallE = 0, stallM = 0, flushE = 0, flushM = 0;
  logic        branchD = 0, pred_takeD = 0, redirect_ready = 1;
  logic [2:0]  branch_typeD = 3'd0;
  logic [31:0] pcD = 0, branch_targetD = 0, srcaE = 0, srcbE = 0;

  logic        branchM, actual_takeM, mispredictM, flush_frontend, redirect_valid, dbg_state;
  logic [31:0] pcM, redirect_pc, br_count, mispred_count;
  logic        branchM_s, actual_takeM_s, mispredictM_s, flush_frontend_s, redirect_valid_s, dbg_state_s;
  logic [31:0] pcM_s, redirect_pc_s;
  logic [3:0]  br_count_s, mispred_count_s;

  branch_resolve_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stallE(stallE), .stallM(stallM), .flushE(flushE), .flushM(flushM),
    .branchD(branchD), .branch_typeD(branch_typeD), .pred_takeD(pred_takeD), .pcD(pcD),
    .branch_targetD(branch_targetD), .srcaE(srcaE), .srcbE(srcbE), .redirect_ready(redirect_ready),
    .branchM(branchM), .actual_takeM(actual_takeM), .pcM(pcM), .mispredictM(mispredictM),
    .flush_frontend(flush_frontend), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_count(br_count), .mispred_count(mispred_count), .dbg_state(dbg_state)
  );

  branch_resolve_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .stallE(stallE), .stallM(stallM), .flushE(flushE), .flushM(flushM),
    .branchD(branchD), .branch_typeD(branch_typeD), .pred_takeD(pred_takeD), .pcD(pcD),
    .branch_targetD(branch_targetD), .srcaE(srcaE), .srcbE(srcbE), .redirect_ready(redirect_ready),
    .branchM(branchM_s), .actual_takeM(actual_takeM_s), .pcM(pcM_s), .mispredictM(mispredictM_s),
    .flush_frontend(flush_frontend_s), .redirect_valid(redirect_valid_s), .redirect_pc(redirect_pc_s),
    .br_count(br_count_s), .mispred_count(mispred_count_s), .dbg_state(dbg_state_s)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mis = 0;
  logic [31:0] exp_q[$];

  function automatic bit ref_take(input logic [2:0] t, input int a, input int b);
    case (t)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return a <= 0;
      3'd3:    return a > 0;
      3'd4:    return a < 0;
      3'd5:    return a >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sat15(input int v);
    return (v > 15) ? 32'd15 : 32'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts();
    chk("br_count", br_count, 32'(exp_br));
    chk("mispred_count", mispred_count, 32'(exp_mis));
    chk("br_count_sat", {28'd0, br_count_s}, sat15(exp_br));
    chk("mispred_count_sat", {28'd0, mispred_count_s}, sat15(exp_mis));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic [2:0] t, input logic p, input logic [31:0] pc, input logic [31:0] tgt);
    branchD = 1'b1; branch_typeD = t; pred_takeD = p; pcD = pc; branch_targetD = tgt;
  endtask

  // One branch through D/E/M; fetch holds off ready for wait_n cycles after a mispredict.
  task automatic run_branch(input logic [2:0] t, input logic p, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic [31:0] a, input logic [31:0] b,
                            input int wait_n);
    bit tk, ms;
    logic [31:0] exp_pc;
    tk = ref_take(t, a, b);
    ms = (p != tk);
    exp_pc = 32'd0;
    if (ms) exp_q.push_back(tk ? tgt : pc + 32'd8);
    drive_d(t, p, pc, tgt);
    tick();
    branchD = 1'b0; pcD = $urandom; branch_targetD = $urandom;
    srcaE = a; srcbE = b;
    tick();
    srcaE = $urandom; srcbE = $urandom;
    redirect_ready = (wait_n == 0);
    @(negedge clk);
    chk("branchM", {31'd0, branchM}, 32'd1);
    chk("actual_takeM", {31'd0, actual_takeM}, {31'd0, tk});
    chk("pcM", pcM, pc);
    chk("mispredictM", {31'd0, mispredictM}, {31'd0, ms});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, ms});
    chk("flush_frontend", {31'd0, flush_frontend}, {31'd0, ms});
    if (ms) begin
      exp_pc = exp_q.pop_front();
      chk("redirect_pc", redirect_pc, exp_pc);
    end
    exp_br++;
    if (ms) exp_mis++;
    if (ms) begin
      for (int k = 1; k <= wait_n; k++) begin
        tick();
        redirect_ready = (k == wait_n);
        @(negedge clk);
        chk("wait_state", {31'd0, dbg_state}, 32'd1);
        chk("wait_valid", {31'd0, redirect_valid}, 32'd1);
        chk("wait_flush", {31'd0, flush_frontend}, 32'd1);
        chk("wait_pc_stable", redirect_pc, exp_pc);
        chk("wait_no_branchM", {31'd0, branchM}, 32'd0);
      end
    end
    tick();
    redirect_ready = 1'b1;
    @(negedge clk);
    chk("idle_state", {31'd0, dbg_state}, 32'd0);
    chk("idle_valid", {31'd0, redirect_valid}, 32'd0);
    chk("single_branchM", {31'd0, branchM}, 32'd0);
    chk_counts();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] a, b;
    tick();
    tick();
    @(negedge clk);
    chk("rst_branchM", {31'd0, branchM}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_pcM", pcM, 32'd0);
    chk_counts();
    rst = 1'b0;
    tick();

    // correct prediction, then both mispredict flavours
    run_branch(3'd0, 1'b1, 32'hBFC0_0010, 32'hBFC0_0200, 32'd5, 32'd5, 0);
    run_branch(3'd3, 1'b0, 32'hBFC0_0020, 32'hBFC0_0100, 32'd3, 32'd0, 0);
    run_branch(3'd1, 1'b1, 32'hBFC0_0040, 32'hBFC0_0300, 32'd7, 32'd7, 0);
    // fetch back-pressure for 3 cycles
    run_branch(3'd4, 1'b0, 32'hBFC0_0060, 32'hBFC0_0400, 32'hFFFF_FFFF, 32'd0, 3);

    // reset while holding a redirect
    drive_d(3'd2, 1'b0, 32'hBFC0_0080, 32'hBFC0_0500);
    tick();
    branchD = 1'b0; srcaE = 32'd0; srcbE = 32'd9;
    tick();
    redirect_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, redirect_valid}, 32'd1);
    tick();
    @(negedge clk);
    chk("pre_rst_wait", {31'd0, dbg_state}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_br = 0; exp_mis = 0; exp_q.delete();
    @(negedge clk);
    chk("post_rst_state", {31'd0, dbg_state}, 32'd0);
    chk("post_rst_valid", {31'd0, redirect_valid}, 32'd0);
    chk("post_rst_flush", {31'd0, flush_frontend}, 32'd0);
    chk("post_rst_pc", redirect_pc, 32'd0);
    chk("post_rst_branchM", {31'd0, branchM}, 32'd0);
    chk("post_rst_mis", {31'd0, mispredictM}, 32'd0);
    chk("post_rst_take", {31'd0, actual_takeM}, 32'd0);
    chk("post_rst_pcM", pcM, 32'd0);
    chk_counts();
    redirect_ready = 1'b1;

    // stallM on a committing branch for 2 cycles
    drive_d(3'd0, 1'b1, 32'hBFC0_00A0, 32'hBFC0_0600);
    tick();
    branchD = 1'b0; srcaE = 32'd4; srcbE = 32'd4;
    tick();
    stallM = 1'b1; stallE = 1'b1;
    @(negedge clk);
    chk("stall1_branchM", {31'd0, branchM}, 32'd0);
    tick();
    @(negedge clk);
    chk("stall2_branchM", {31'd0, branchM}, 32'd0);
    chk("stall2_pcM", pcM, 32'hBFC0_00A0);
    tick();
    stallM = 1'b0; stallE = 1'b0;
    @(negedge clk);
    chk("release_branchM", {31'd0, branchM}, 32'd1);
    chk("release_take", {31'd0, actual_takeM}, 32'd1);
    exp_br++;
    tick();
    @(negedge clk);
    chk("release_once", {31'd0, branchM}, 32'd0);
    chk_counts();

    // flushE as the branch enters E; flushM as it enters M
    drive_d(3'd3, 1'b0, 32'hBFC0_00C0, 32'hBFC0_0700);
    flushE = 1'b1;
    tick();
    flushE = 1'b0; branchD = 1'b0; srcaE = 32'd1;
    tick();
    @(negedge clk);
    chk("flushE_branchM", {31'd0, branchM}, 32'd0);
    chk("flushE_valid", {31'd0, redirect_valid}, 32'd0);
    tick();
    drive_d(3'd3, 1'b0, 32'hBFC0_00E0, 32'hBFC0_0800);
    tick();
    branchD = 1'b0; srcaE = 32'd1; flushM = 1'b1;
    tick();
    flushM = 1'b0;
    @(negedge clk);
    chk("flushM_branchM", {31'd0, branchM}, 32'd0);
    tick();
    chk_counts();

    // 17 mispredicts: the 4-bit instance saturates at 15
    for (int i = 0; i < 17; i++)
      run_branch(3'd5, 1'b0, $urandom & 32'hFFFF_FFFC, $urandom, 32'd0, $urandom, 0);

    // randomized branches
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'd0;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'($urandom_range(1, 10));
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 1) == 1) ? a : $urandom;
      run_branch(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                 a, b, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
